fila_prefetch: RTL and testbench
================================

Name: fila_prefetch

Overview:
- Instruction prefetch queue between instruction memory and the fetch/control path.
- Fetches sequential instruction words ahead of consumption over a req/ack memory handshake with variable latency.
- Presents the head instruction and its PC to the consumer.
- On a taken jump, flushes all buffered words, discards any in-flight response and restarts fetch at the jump target.

Parameters:
- DEPTH, 4, queue entries (power of two, ≥2).
- DATA_W, 32, instruction word width.
- ADDR_W, 32, PC/address width.
- RESET_PC, 0, first fetch address after reset.
- PC_STEP, 1, PC increment per word (word-addressed memory).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- mem_req  out  1  fetch request; held high until mem_ack.
- mem_addr  out  ADDR_W  fetch address; stable while mem_req is high.
- mem_ack  in  1  one-cycle pulse; mem_rdata is valid this cycle.
- mem_rdata  in  DATA_W  returned instruction word.
- habJump  in  1  redirect strobe (taken jump).
- jumpPC  in  ADDR_W  redirect target, sampled when habJump=1.
- instr_valid  out  1  queue non-empty.
- instrucao  out  DATA_W  head instruction; 0 when empty.
- pc_out  out  ADDR_W  PC of head instruction; 0 when empty.
- instr_ready  in  1  consumer pops head when instr_valid & instr_ready.
- ocupacao  out  $clog2(DEPTH)+1  current entry count.

Behaviour:
- Reset (reset=0, asynchronous):
  - mem_req=0, mem_addr=RESET_PC, fetch_pc=RESET_PC, state=FETCH.
  - count=0, rd/wr pointers=0, so instr_valid=0, instrucao=0, pc_out=0, ocupacao=0.
  - Reset mid-request abandons the request; a later stray mem_ack is ignored until the new request is issued.
- Single outstanding request. State machine:
  - FETCH: if count < DEPTH (after this cycle's pop), assert mem_req with mem_addr=fetch_pc next edge → WAIT. Otherwise stay.
  - WAIT: mem_req=1. On mem_ack:
    - push {fetch_pc, mem_rdata}.
    - fetch_pc += PC_STEP (wraps modulo 2^ADDR_W).
    - drop mem_req.
    - → FETCH. Back-to-back requests are allowed: next req is asserted the cycle after ack if space exists.
  - DISCARD: mem_req stays high (address may not change mid-request). On mem_ack: drop data, drop mem_req, → FETCH with fetch_pc already = target.
- Space rule: a request is issued only if count + outstanding < DEPTH counting the same-cycle pop, so a push never overflows. A full queue stalls fetch with mem_req=0.
- Latency: ack at edge N → instr_valid=1 and instrucao=data after edge N. From reset release, the first request is visible after the first clock edge.
- Pop: when instr_valid & instr_ready, rd pointer advances and count decrements. Pop on empty has no effect.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Redirect (habJump=1), priority over everything:
  - count:=0, pointers:=0, fetch_pc:=jumpPC.
  - Same-cycle pop and push are ignored.
  - If in WAIT without ack → DISCARD.
  - If in WAIT with ack this cycle → data dropped, → FETCH.
  - If in FETCH → FETCH; the next request goes to jumpPC.
  - instr_valid=0 the cycle after habJump.
- habJump while in DISCARD: update fetch_pc to the new jumpPC, stay in DISCARD.
- mem_ack while mem_req=0 is ignored.
- ocupacao equals count; it never exceeds DEPTH.

Decomposition:
- Shared package (pacote_processador):
  - state enum {FETCH, WAIT, DISCARD}.
  - ADDR_W/DATA_W defaults.
  - RESET_PC constant.
- One natural sub-module: fila_circular, a DEPTH×(ADDR_W+DATA_W) circular buffer.
  - Ports: push, pop, flush, din, dout, count, full, empty.
  - Contains pointer wrap logic.
- The FSM and fetch_pc stay in fila_prefetch.

Test Plan:
- Reset release, memory acks 1 cycle after req, instr_ready=1 → addresses 0,1,2,3… requested. Head shows {pc=0,instr=mem[0]} after the first ack, then increments each accepted word.
- instr_ready=0, instant ack → exactly 4 words buffered (ocupacao=4). mem_req stays 0 while full. A single pop triggers exactly one new request at addr 4.
- Ack latency 5 cycles, habJump with jumpPC=0x40 at cycle 2 of a wait:
  - mem_addr stays at the old address until ack, and that data is discarded.
  - Next request is at 0x40.
  - First valid head is pc_out=0x40.
- habJump in the same cycle as mem_ack and pop with 2 entries queued → queue empty next cycle, acked word not pushed, next mem_addr=jumpPC.
- Wrap-around: fetch_pc=0xFFFFFFFF acked → next mem_addr=0x00000000. Pointers wrap after 10 push/pop pairs with count constant at 1.
- Reset asserted while mem_req=1 → outputs return to reset values immediately. After release, the request restarts at RESET_PC and a late ack during reset is ignored.

Source files
------------

// File: rtl/pacote_processador.sv
// Shared definitions for the instruction fetch path: FSM state encoding and
// default widths / reset address.
package pacote_processador;

  localparam int          DEF_ADDR_W   = 32;
  localparam int          DEF_DATA_W   = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    DISCARD
  } estado_t;

endpackage

// File: rtl/fila_circular.sv
// DEPTH-entry circular buffer with synchronous flush; pointers wrap naturally
// because DEPTH is a power of two.
module fila_circular #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] cnt;
  logic          do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];
  assign count   = cnt;

  // NOTE: the storage array has no reset; only pointers and count qualify its contents.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/fila_prefetch.sv
// Instruction prefetch queue: keeps one sequential fetch in flight over a
// req/ack memory handshake and flushes/redirects on a taken jump.
module fila_prefetch
  import pacote_processador::*;
#(
  parameter int                DEPTH    = 4,
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
  parameter int                PC_STEP  = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic                     mem_ack,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     habJump,
  input  logic [ADDR_W-1:0]        jumpPC,
  output logic                     instr_valid,
  output logic [DATA_W-1:0]        instrucao,
  output logic [ADDR_W-1:0]        pc_out,
  input  logic                     instr_ready,
  output logic [$clog2(DEPTH):0]   ocupacao
);

  estado_t                  state_q, state_d;
  logic [ADDR_W-1:0]        fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]        addr_d;
  logic                     req_d;
  logic                     q_push, q_pop, q_full, q_empty;
  logic [ADDR_W+DATA_W-1:0] q_dout;

  fila_circular #(
    .DEPTH (DEPTH),
    .W     (ADDR_W + DATA_W)
  ) u_fila (
    .clk   (clock),
    .rst_n (reset),
    .push  (q_push),
    .pop   (q_pop),
    .flush (habJump),
    .din   ({fetch_pc_q, mem_rdata}),
    .dout  (q_dout),
    .count (ocupacao),
    .full  (q_full),
    .empty (q_empty)
  );

  assign instr_valid = !q_empty;
  assign instrucao   = q_empty ? '0 : q_dout[DATA_W-1:0];
  assign pc_out      = q_empty ? '0 : q_dout[ADDR_W+DATA_W-1:DATA_W];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      mem_req    <= 1'b0;
      mem_addr   <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_req    <= req_d;
      mem_addr   <= addr_d;
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_d      = mem_req;
    addr_d     = mem_addr;
    q_push     = 1'b0;
    q_pop      = instr_valid && instr_ready && !habJump;

    case (state_q)
      FETCH: begin
        // A full queue still has room when this cycle's pop frees a slot.
        if (habJump) begin
          fetch_pc_d = jumpPC;
        end else if (!q_full || q_pop) begin
          req_d   = 1'b1;
          addr_d  = fetch_pc_q;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_ack) begin
          req_d   = 1'b0;
          state_d = FETCH;
          if (habJump) begin
            fetch_pc_d = jumpPC;
          end else begin
            q_push     = 1'b1;
            fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
          end
        end else if (habJump) begin
          fetch_pc_d = jumpPC;
          state_d    = DISCARD;
        end
      end
      DISCARD: begin
        // The stale request must complete before the target can be fetched.
        if (habJump) fetch_pc_d = jumpPC;
        if (mem_ack) begin
          req_d   = 1'b0;
          state_d = FETCH;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_fila_prefetch.sv
// Directed bench for fila_prefetch: sequential fetch, full stall, redirect
// during a slow fetch, redirect with ack, PC/pointer wrap and reset mid-request.
module tb_fila_prefetch;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        habJump = 1'b0;
  logic [31:0] jumpPC = '0;
  logic        instr_valid;
  logic [31:0] instrucao;
  logic [31:0] pc_out;
  logic        instr_ready = 1'b0;
  logic [2:0]  ocupacao;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clock = ~clock;

  fila_prefetch dut (
    .clock       (clock),
    .reset       (reset),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .habJump     (habJump),
    .jumpPC      (jumpPC),
    .instr_valid (instr_valid),
    .instrucao   (instrucao),
    .pc_out      (pc_out),
    .instr_ready (instr_ready),
    .ocupacao    (ocupacao)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic ack_now(input logic [31:0] data);
    mem_ack   = 1'b1;
    mem_rdata = data;
    step();
    mem_ack   = 1'b0;
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    mem_ack     = 1'b0;
    habJump     = 1'b0;
    instr_ready = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    #1;
    check("rst_req",   mem_req,     0);
    check("rst_addr",  mem_addr,    0);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instrucao,   0);
    check("rst_pc",    pc_out,      0);
    check("rst_ocup",  ocupacao,    0);

    // Sequential fetch, 1-cycle ack, consumer always ready
    do_reset();
    instr_ready = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      check("seq_req",   mem_req,  1);
      check("seq_addr",  mem_addr, 32'(i));
      ack_now(word_at(32'(i)));
      check("seq_valid", instr_valid, 1);
      check("seq_pc",    pc_out,   32'(i));
      check("seq_instr", instrucao, word_at(32'(i)));
      step();
    end

    // Fill to DEPTH with consumer stalled, then single pop
    do_reset();
    step();
    for (int i = 0; i < 4; i++) begin
      check("fill_addr", mem_addr, 32'(i));
      ack_now(word_at(32'(i)));
      if (i < 3) step();
    end
    check("full_ocup", ocupacao, 4);
    check("full_req",  mem_req,  0);
    step();
    check("full_stall_req", mem_req, 0);
    check("full_head_pc",   pc_out,  0);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    check("pop_req",  mem_req,  1);
    check("pop_addr", mem_addr, 4);
    check("pop_ocup", ocupacao, 3);
    check("pop_head", pc_out,   1);
    ack_now(word_at(32'd4));
    check("refill_ocup", ocupacao, 4);
    step();
    check("refill_req",  mem_req,  0);

    // Slow fetch redirected twice (second while discarding)
    do_reset();
    instr_ready = 1'b1;
    step();
    habJump = 1'b1; jumpPC = 32'h20;
    step();
    jumpPC = 32'h40;
    step();
    habJump = 1'b0;
    check("disc_req",   mem_req,     1);
    check("disc_addr",  mem_addr,    0);
    check("disc_valid", instr_valid, 0);
    step();
    step();
    ack_now(word_at(32'd0));
    check("disc_drop_req",   mem_req,  0);
    check("disc_drop_valid", instr_valid, 0);
    check("disc_drop_ocup",  ocupacao, 0);
    step();
    check("jmp_req",  mem_req,  1);
    check("jmp_addr", mem_addr, 32'h40);
    ack_now(word_at(32'h40));
    check("jmp_valid", instr_valid, 1);
    check("jmp_pc",    pc_out,      32'h40);
    check("jmp_instr", instrucao,   word_at(32'h40));

    // Redirect coinciding with ack and pop, two entries queued
    do_reset();
    step();
    ack_now(word_at(32'd0));
    step();
    ack_now(word_at(32'd1));
    step();
    check("hj2_ocup_pre", ocupacao, 2);
    check("hj2_addr_pre", mem_addr, 2);
    mem_ack = 1'b1; mem_rdata = word_at(32'd2);
    habJump = 1'b1; jumpPC = 32'h100; instr_ready = 1'b1;
    step();
    mem_ack = 1'b0; habJump = 1'b0; instr_ready = 1'b0;
    check("hj2_ocup",  ocupacao,    0);
    check("hj2_valid", instr_valid, 0);
    check("hj2_instr", instrucao,   0);
    check("hj2_pc",    pc_out,      0);
    check("hj2_req",   mem_req,     0);
    step();
    check("hj2_next_req",  mem_req,  1);
    check("hj2_next_addr", mem_addr, 32'h100);

    // PC wrap at 2^32 and pointer wrap with occupancy held at 1
    do_reset();
    instr_ready = 1'b1;
    step();
    mem_ack = 1'b1; habJump = 1'b1; jumpPC = 32'hFFFF_FFFF;
    step();
    mem_ack = 1'b0; habJump = 1'b0;
    step();
    check("wrap_addr_hi", mem_addr, 32'hFFFF_FFFF);
    ack_now(word_at(32'hFFFF_FFFF));
    check("wrap_pc_hi", pc_out, 32'hFFFF_FFFF);
    step();
    check("wrap_addr_lo",  mem_addr,    0);
    check("wrap_valid_lo", instr_valid, 0);
    instr_ready = 1'b0;
    ack_now(word_at(32'd0));
    check("wrap_head0", pc_out, 0);
    for (int k = 1; k <= 10; k++) begin
      step();
      check("ptr_addr", mem_addr, 32'(k));
      mem_ack = 1'b1; mem_rdata = word_at(32'(k)); instr_ready = 1'b1;
      step();
      mem_ack = 1'b0; instr_ready = 1'b0;
      check("ptr_ocup",  ocupacao,  1);
      check("ptr_pc",    pc_out,    32'(k));
      check("ptr_instr", instrucao, word_at(32'(k)));
    end

    // Reset asserted mid-request, ack straddling the release
    do_reset();
    step();
    check("mid_req_pre", mem_req, 1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_req",   mem_req,     0);
    check("mid_rst_addr",  mem_addr,    0);
    check("mid_rst_valid", instr_valid, 0);
    check("mid_rst_ocup",  ocupacao,    0);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step();
    step();
    reset = 1'b1;
    step();
    mem_ack = 1'b0;
    check("post_rst_req",   mem_req,     1);
    check("post_rst_addr",  mem_addr,    0);
    check("post_rst_ocup",  ocupacao,    0);
    check("post_rst_valid", instr_valid, 0);
    ack_now(word_at(32'd0));
    check("post_rst_instr", instrucao, word_at(32'd0));
    check("post_rst_pc",    pc_out,    0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
